// File: rtl/l1_bus_ctrl.sv
// L1 data-cache bus controller: single reads/writes, line refills and dirty-line write-backs
// as 64-bit beats on a one-outstanding valid/ack bus. Optional macro BUS_TIMEOUT_EN adds a beat watchdog.

module l1_bus_ctrl #(
    parameter int LINE_BEATS = 2048,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_through_req,
    input  logic             read_req,
    input  logic             read_line_req,
    input  logic             write_line_req,
    input  logic [3:0]       L1_size,
    input  logic [63:0]      pa,
    input  logic [63:0]      wt_data,
    output logic [63:0]      line_data,
    output logic [CNT_W-1:0] addr_count,
    output logic             line_write,
    output logic             cache_entry_refill,
    output logic             trans_rdy,
    output logic             bus_error,
    output logic             bus_req,
    output logic             bus_we,
    output logic [63:0]      bus_addr,
    output logic [3:0]       bus_size,
    output logic [63:0]      bus_wdata,
    input  logic             bus_ack,
    input  logic             bus_err,
    input  logic [63:0]      bus_rdata
);

    typedef enum logic [2:0] {
        IDLE, SGL_RD, SGL_WR, LRD, LWR_FETCH, LWR_BUS, DONE
    } state_t;

    localparam int               OFF_W     = $clog2(LINE_BEATS * 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    state_t           r_state;
    logic [63:0]      r_base;
    logic [63:0]      r_line_data;
    logic [63:0]      r_bus_addr;
    logic [63:0]      r_bus_wdata;
    logic [3:0]       r_bus_size;
    logic [CNT_W-1:0] r_addr_count;
    logic             r_line_write;
    logic             r_refill;
    logic             r_trans_rdy;
    logic             r_bus_error;
    logic             r_bus_req;
    logic             r_bus_we;
    logic             r_wait;

    logic [63:0]      w_pa_base;
    logic [63:0]      w_cur_addr;
    logic [63:0]      w_nxt_addr;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last;
    logic             w_timeout;
    logic             w_fail;

    assign w_pa_base  = {pa[63:OFF_W], {OFF_W{1'b0}}};
    assign w_cnt_nxt  = r_addr_count + CNT_W'(1);
    assign w_cur_addr = r_base | (64'(r_addr_count) << 3);
    assign w_nxt_addr = r_base | (64'(w_cnt_nxt) << 3);
    assign w_last     = (r_addr_count == LAST_BEAT);
    // An error (or ack+err together) only counts while a beat is actually outstanding.
    assign w_fail     = r_bus_req & (bus_err | w_timeout);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_timeout = (r_wdog == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst || !r_bus_req || bus_ack || bus_err || w_timeout)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 16'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: all state and outputs live in one clocked block with non-blocking assignments,
    // so every output is a flop and reads of r_* always see the previous cycle's value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_line_data  <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_size   <= '0;
            r_addr_count <= '0;
            r_line_write <= 1'b0;
            r_refill     <= 1'b0;
            r_trans_rdy  <= 1'b0;
            r_bus_error  <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_wait       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each path only has to raise them.
            r_line_write <= 1'b0;
            r_refill     <= 1'b0;
            r_trans_rdy  <= 1'b0;
            r_bus_error  <= 1'b0;

            if (w_fail) begin
                r_bus_error  <= 1'b1;
                r_bus_req    <= 1'b0;
                r_bus_we     <= 1'b0;
                r_addr_count <= '0;
                r_state      <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_addr_count <= '0;
                        r_base       <= w_pa_base;
                        if (write_line_req) begin
                            // Cache RAM output lags addr_count by a cycle; skip the wait if it was already 0.
                            r_wait  <= (r_addr_count != '0);
                            r_state <= LWR_FETCH;
                        end else if (read_line_req) begin
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= w_pa_base;
                            r_bus_size <= 4'b1000;
                            r_state    <= LRD;
                        end else if (read_req) begin
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= pa;
                            r_bus_size <= L1_size;
                            r_state    <= SGL_RD;
                        end else if (write_through_req) begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= 1'b1;
                            r_bus_addr  <= pa;
                            r_bus_size  <= L1_size;
                            r_bus_wdata <= wt_data;
                            r_state     <= SGL_WR;
                        end
                    end
                    SGL_RD: begin
                        if (bus_ack) begin
                            r_line_data <= bus_rdata;
                            r_bus_req   <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                    SGL_WR: begin
                        if (bus_ack) begin
                            r_bus_req <= 1'b0;
                            r_bus_we  <= 1'b0;
                            r_state   <= DONE;
                        end
                    end
                    LRD: begin
                        if (r_bus_req) begin
                            if (bus_ack) begin
                                r_bus_req    <= 1'b0;
                                r_line_data  <= bus_rdata;
                                r_line_write <= 1'b1;
                                if (w_last) begin
                                    r_refill    <= 1'b1;
                                    r_trans_rdy <= 1'b1;
                                    r_state     <= IDLE;
                                end
                            end
                        end else begin
                            r_addr_count <= w_cnt_nxt;
                            r_bus_addr   <= w_nxt_addr;
                            r_bus_req    <= 1'b1;
                        end
                    end
                    LWR_FETCH: begin
                        if (r_wait) begin
                            r_wait <= 1'b0;
                        end else begin
                            r_bus_wdata <= wt_data;
                            r_bus_addr  <= w_cur_addr;
                            r_bus_size  <= 4'b1000;
                            r_bus_we    <= 1'b1;
                            r_bus_req   <= 1'b1;
                            r_state     <= LWR_BUS;
                        end
                    end
                    LWR_BUS: begin
                        if (bus_ack) begin
                            r_bus_req <= 1'b0;
                            r_bus_we  <= 1'b0;
                            if (w_last) begin
                                r_trans_rdy <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_addr_count <= w_cnt_nxt;
                                r_wait       <= 1'b1;
                                r_state      <= LWR_FETCH;
                            end
                        end
                    end
                    DONE: begin
                        r_trans_rdy <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign line_data          = r_line_data;
    assign addr_count         = r_addr_count;
    assign line_write         = r_line_write;
    assign cache_entry_refill = r_refill;
    assign trans_rdy          = r_trans_rdy;
    assign bus_error          = r_bus_error;
    assign bus_req            = r_bus_req;
    assign bus_we             = r_bus_we;
    assign bus_addr           = r_bus_addr;
    assign bus_size           = r_bus_size;
    assign bus_wdata          = r_bus_wdata;

endmodule

// File: doc/l1_bus_ctrl.md
Name: l1_bus_ctrl

Overview:
Cache-side bus controller that serves the L1 data cache's miss, uncached and write-back requests.
- Accepts level-held requests from the L1: single read, write-through, line refill, dirty-line write-back.
- Turns each request into a sequence of 64-bit beats on a single-outstanding valid/ack system bus.
- Returns beat data, a beat index (addr_count) and completion/error pulses that the L1 state machine consumes.

Parameters:
LINE_BEATS, 2048, number of 64-bit beats per cache line (power of two, 2..2048)
CNT_W, 11, width of addr_count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
write_through_req  input  1  single write request (level)
read_req  input  1  single read request (level)
read_line_req  input  1  line refill request (level)
write_line_req  input  1  dirty-line write-back request (level)
L1_size  input  4  single-access size, one-hot 0001/0010/0100/1000 = 1/2/4/8 B
pa  input  64  physical address
wt_data  input  64  write data; for write-back, cache RAM output for current addr_count, valid 1 cycle after addr_count changes
line_data  output  64  returned read data (registered)
addr_count  output  CNT_W  current beat index within line
line_write  output  1  one-cycle pulse per refill beat; line_data/addr_count valid
cache_entry_refill  output  1  one-cycle pulse with final refill beat
trans_rdy  output  1  one-cycle pulse: transaction complete
bus_error  output  1  one-cycle pulse: transaction aborted
bus_req  output  1  beat request on system bus
bus_we  output  1  1 = write beat
bus_addr  output  64  beat address
bus_size  output  4  beat size
bus_wdata  output  64  write data
bus_ack  input  1  beat accepted/completed
bus_err  input  1  beat failed (valid when bus_req high)
bus_rdata  input  64  read data, valid with bus_ack

Behaviour:
- Reset: state IDLE. All outputs 0: line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata. Reset mid-transaction aborts immediately; bus_req drops the next cycle and no completion pulse is issued.
- Bus rule: bus_req, bus_we, bus_addr, bus_size and bus_wdata stay stable from assertion until the cycle bus_ack or bus_err is sampled high. bus_req drops the cycle after. At most one beat is outstanding.
- Request priority, sampled in IDLE: write_line_req > read_line_req > read_req > write_through_req. pa is latched on entry.
- Line base address is pa with the low log2(LINE_BEATS*8) bits cleared. Beat address = base + addr_count*8. Line beats use bus_size=4'b1000.
- States:
  - IDLE: dispatch as above; addr_count=0.
  - SGL_RD: bus_req, bus_we=0, bus_addr=pa, bus_size=L1_size. On ack: line_data<=bus_rdata, go to DONE.
  - SGL_WR: same as SGL_RD with bus_we=1 and bus_wdata=wt_data sampled on entry. On ack go to DONE.
  - LRD: per beat, read request. On ack: line_data<=bus_rdata, line_write=1 for one cycle with the current addr_count. addr_count increments the cycle after. On the last beat (addr_count==LINE_BEATS-1), line_write, cache_entry_refill and trans_rdy all pulse in the same cycle, then go to IDLE.
  - LWR_FETCH: wait one cycle for cache RAM read latency, capture wt_data into bus_wdata, go to LWR_BUS.
  - LWR_BUS: write beat. On ack: if last beat, pulse trans_rdy and go to IDLE; else increment addr_count and go to LWR_FETCH.
  - DONE: pulse trans_rdy for one cycle with line_data held, then go to IDLE.
- trans_rdy, line_write, cache_entry_refill and bus_error are all registered outputs.
- Between consecutive requests there is always at least one IDLE cycle. A write-back sequence re-requests with a new pa, which is latched fresh.
- Error: bus_err sampled high during any bus state pulses bus_error for one cycle, gives no trans_rdy and no further line_write, clears addr_count and returns to IDLE. bus_ack and bus_err high in the same cycle is treated as an error.
- Latency with zero-wait ack: single read = 3 cycles from request to trans_rdy. Line refill = LINE_BEATS*2 cycles. Write-back = LINE_BEATS*3 cycles.
- addr_count never wraps within a line; it is held after the last beat until IDLE resets it.
- A request deasserted mid-transaction is ignored; the transaction completes.

Optional Feature:
BUS_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles with bus_req high and no ack/err. When it reaches 16'hFFFF, the controller behaves exactly as if bus_err were sampled high: bus_error pulse, return to IDLE. The watchdog clears on every ack and on leaving a bus state.
- Undefined: no watchdog; the controller waits indefinitely for ack/err.

Test Plan (LINE_BEATS=4 override):
- read_req, pa=0x1000_0004, L1_size=0100, ack with rdata=0xDEAD_BEEF after 2 wait cycles -> bus_addr=0x1000_0004, bus_size=0100, bus_we=0; trans_rdy pulses once with line_data=0xDEAD_BEEF.
- read_line_req, pa=0x2000_0018, zero-wait ack, rdata=beat index -> bus_addr 0x2000_0000/08/10/18; 4 line_write pulses with addr_count 0..3; cache_entry_refill and trans_rdy on beat 3 only.
- write_line_req, pa=0x3000_0000, wt_data=0xA0+addr_count with 1-cycle latency -> 4 writes, bus_wdata A0..A3 at addresses 0x3000_0000..18; single trans_rdy.
- write_line_req and read_req asserted together -> write-back runs first; the read starts after the IDLE cycle.
- read_line_req with bus_err on beat 2 -> 2 line_write pulses, then bus_error pulse, no trans_rdy or cache_entry_refill; addr_count=0 in IDLE.
- rst asserted during LWR_BUS -> all outputs 0 next cycle; a following read_req completes normally. With BUS_TIMEOUT_EN defined, no ack for 65535 cycles -> bus_error pulse.
